sdm_interp: RTL and testbench
=============================

Name: sdm_interp

Overview:
- Linear-interpolating upsampler directly upstream of the first-order sigma-delta modulator.
- Accepts signed audio-rate samples over a valid/ready handshake and produces one interpolated signed sample every clk, which drives the modulator's din.
- Upsampling ratio is 2^OSR_LOG2. Input starvation holds the last sample and flags an underrun.

Parameters:
- N, 16, sample width (signed two's complement), input and output.
- OSR_LOG2, 6, log2 of upsampling ratio R = 2^OSR_LOG2; legal 1..10.
- CNTW, 16, underrun counter width.

Ports:
- clk  in  1  single clock.
- areset  in  1  asynchronous reset, active-high.
- s_data  in  N  input sample, signed.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept; transfer when s_valid & s_ready at posedge.
- dout  out  N  interpolated sample to modulator, signed.
- dout_valid  out  1  dout meaningful.
- underrun  out  1  one-cycle pulse on starvation.
- underrun_cnt  out  CNTW  saturating count of underrun pulses.

Behaviour:
- Reset (areset high, async): state=IDLE; dout=0; dout_valid=0; underrun=0; underrun_cnt=0; buffer empty. s_ready forced 0 while areset high.
- Input buffer: one entry (nxt, nxt_valid). s_ready = ~nxt_valid (registered flag). An accept sets nxt_valid.
- Datapath registers:
  - x1 (segment end, N bits).
  - delta = x1 - x0 (N+1 bits, signed, no overflow).
  - acc (N+OSR_LOG2+1 bits, signed).
  - ph (OSR_LOG2 bits).
  - dout = acc >>> OSR_LOG2 (arithmetic shift, floor), truncated to N bits. The result always lies between x0 and x1, so truncation is lossless.
- "Sample available" (avail) = nxt_valid, OR (nxt_valid=0 AND s_valid & s_ready this cycle). The second case is the bypass path: s_data is used directly and nxt is not written.
- IDLE:
  - dout_valid=0.
  - On avail: x1<=sample, acc<=sample<<<OSR_LOG2, go HOLD. No underrun pulse.
  - First sample accepted at edge k gives dout=sample and dout_valid=1 from k+1.
- HOLD:
  - dout_valid=1; dout=x1 constant; ph=0.
  - On avail: delta<=sample-x1, x1<=sample, acc unchanged (still old x1<<<OSR_LOG2), ph<=0, consume buffer, go RUN.
- RUN:
  - Each cycle: acc<=acc+delta, ph<=ph+1 (wraps at R).
  - At ph=R-1 (wrap):
    - If avail: delta<=sample-x1, x1<=sample, acc<=x1<<<OSR_LOG2 (exact segment start, no accumulated error), consume, stay RUN.
    - Else: acc<=x1<<<OSR_LOG2, go HOLD, pulse underrun at the next cycle, underrun_cnt+=1 (saturate at all-ones).
- Output sequence per segment: x0 + floor(delta*ph/R) for ph=0..R-1, then x1 at the next segment start. Continuous, no repeated or dropped samples.
- Steady state with s_valid held high: exactly one accept per R cycles; no underrun.
- Buffer fill and consume in the same cycle: consume happens first, then the fill. Ordering is guaranteed by s_ready being registered: a fill can only occur when nxt_valid=0.
- Reset mid-operation: immediate return to reset values; any buffered sample is discarded.
- Full-scale step (-2^(N-1) to 2^(N-1)-1) must be handled without overflow.

Decomposition:
- Shared package sdm_pkg:
  - State enum (IDLE, HOLD, RUN).
  - Derived width constants ACCW = N+OSR_LOG2+1 and DW = N+1.
  - Saturating-increment helper.
- One sub-module: sdm_in_buf (one-entry buffer holding nxt/nxt_valid, s_ready, bypass mux, consume input).

Test Plan (N=16, OSR_LOG2=2, R=4):
- Reset: hold areset high 3 cycles with s_valid=1 -> s_ready=0, dout=0, dout_valid=0; release -> s_ready=1, no accept during reset.
- Ramp: send 0, then 400 one cycle later, then nothing -> dout 0 (HOLD), then 0,100,200,300, then 400 held; underrun pulses once, underrun_cnt=1.
- Full-scale: send -32768 then 32767 -> RUN outputs -32768, -16385, -1, 16383, then 32767; no overflow.
- Backpressure: s_valid held high, data 1000,2000,3000,... -> accepts exactly every 4 cycles in RUN; outputs 1000,1250,1500,1750,2000,...; underrun never asserts.
- Bypass: buffer empty, present 800 with s_valid only in the cycle where ph=3 (segment 0->400) -> next outputs 400,500,600,700, no underrun.
- Mid-RUN reset: assert areset at ph=2 with buffer full -> all outputs return to reset values at once; after release, first accepted sample appears alone in HOLD, and the previously buffered sample does not reappear.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared types and helpers for the sigma-delta interpolating upsampler.
package sdm_pkg;

   // Interpolator control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Default geometry (sample width 16, ratio 64).
   localparam int N_DEF        = 16;
   localparam int OSR_LOG2_DEF = 6;

   // Accumulator needs the sample, the fractional phase bits and one guard bit.
   function automatic int acc_width(input int n, input int osr_log2);
      return n + osr_log2 + 1;
   endfunction

   // Segment slope spans the full difference of two N-bit samples.
   function automatic int delta_width(input int n);
      return n + 1;
   endfunction

   localparam int ACCW = acc_width(N_DEF, OSR_LOG2_DEF);
   localparam int DW   = delta_width(N_DEF);

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] max_v;
      max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      return (v >= max_v) ? max_v : (v + 64'd1);
   endfunction

endpackage

// File: rtl/sdm_interp_in_buf.sv
// One-entry input buffer with a bypass path straight from s_data.
module sdm_in_buf
   import sdm_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         areset,
   input  logic [N-1:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         consume,
   output logic         avail,
   output logic [N-1:0] sample
);

   logic [N-1:0] nxt_q, nxt_d;
   logic         nxt_valid_q, nxt_valid_d;
   logic         accept;

   // Ready comes from a register so a fill can only land in an empty slot.
   assign s_ready = ~nxt_valid_q & ~areset;
   assign accept  = s_valid & s_ready;
   assign avail   = nxt_valid_q | accept;
   assign sample  = nxt_valid_q ? nxt_q : s_data;

   // Consume empties the slot; an accept not consumed in the same cycle fills it.
   always_comb begin
      nxt_d       = nxt_q;
      nxt_valid_d = nxt_valid_q;
      if (consume) begin
         nxt_valid_d = 1'b0;
      end
      if (accept && !consume) begin
         nxt_d       = s_data;
         nxt_valid_d = 1'b1;
      end
   end

   // Buffer registers; reset discards any held sample.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         nxt_q       <= '0;
         nxt_valid_q <= 1'b0;
      end else begin
         nxt_q       <= nxt_d;
         nxt_valid_q <= nxt_valid_d;
      end
   end

endmodule

// File: rtl/sdm_interp.sv
// Linear-interpolating upsampler feeding the first-order sigma-delta modulator.
module sdm_interp
   import sdm_pkg::*;
#(
   parameter int N        = 16,
   parameter int OSR_LOG2 = 6,
   parameter int CNTW     = 16
) (
   input  logic            clk,
   input  logic            areset,
   input  logic [N-1:0]    s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic [N-1:0]    dout,
   output logic            dout_valid,
   output logic            underrun,
   output logic [CNTW-1:0] underrun_cnt
);

   localparam int ACC_W = acc_width(N, OSR_LOG2);
   localparam int D_W   = delta_width(N);

   state_e              state_q, state_d;
   logic [N-1:0]        x1_q, x1_d;
   logic [D_W-1:0]      delta_q, delta_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [OSR_LOG2-1:0] ph_q, ph_d;
   logic                underrun_q, underrun_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;

   logic                avail;
   logic                consume;
   logic [N-1:0]        sample;
   logic [ACC_W-1:0]    x1_start;
   logic [ACC_W-1:0]    sample_start;
   logic [D_W-1:0]      new_delta;
   logic [ACC_W-1:0]    delta_ext;

   sdm_in_buf #(.N(N)) u_in_buf (
      .clk     (clk),
      .areset  (areset),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .consume (consume),
      .avail   (avail),
      .sample  (sample)
   );

   // Segment endpoints scaled to accumulator units, and the next segment slope.
   assign x1_start     = {{(OSR_LOG2 + 1){x1_q[N-1]}}, x1_q, {OSR_LOG2{1'b0}}};
   assign sample_start = {{(OSR_LOG2 + 1){sample[N-1]}}, sample, {OSR_LOG2{1'b0}}};
   assign new_delta    = {sample[N-1], sample} - {x1_q[N-1], x1_q};
   assign delta_ext    = {{OSR_LOG2{delta_q[D_W-1]}}, delta_q};

   // Floor division by R is just dropping the fractional bits; the result
   // always lies between the segment endpoints so the top guard bit is redundant.
   assign dout         = acc_q[OSR_LOG2 +: N];
   assign dout_valid   = (state_q != IDLE);
   assign underrun     = underrun_q;
   assign underrun_cnt = cnt_q;

   // Next-state and datapath update for the IDLE/HOLD/RUN interpolator.
   always_comb begin
      state_d    = state_q;
      x1_d       = x1_q;
      delta_d    = delta_q;
      acc_d      = acc_q;
      ph_d       = ph_q;
      consume    = 1'b0;
      underrun_d = 1'b0;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (avail) begin
               x1_d    = sample;
               acc_d   = sample_start;
               consume = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            ph_d = '0;
            if (avail) begin
               delta_d = new_delta;
               x1_d    = sample;
               consume = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q + delta_ext;
            ph_d  = ph_q + 1'b1;
            if (ph_q == {OSR_LOG2{1'b1}}) begin
               // Restart from the exact segment end so no rounding error carries over.
               acc_d = x1_start;
               if (avail) begin
                  delta_d = new_delta;
                  x1_d    = sample;
                  consume = 1'b1;
               end else begin
                  state_d    = HOLD;
                  underrun_d = 1'b1;
                  cnt_d      = CNTW'(sat_inc(64'(cnt_q), CNTW));
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q    <= IDLE;
         x1_q       <= '0;
         delta_q    <= '0;
         acc_q      <= '0;
         ph_q       <= '0;
         underrun_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         x1_q       <= x1_d;
         delta_q    <= delta_d;
         acc_q      <= acc_d;
         ph_q       <= ph_d;
         underrun_q <= underrun_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sdm_interp.sv
// Directed bench for sdm_interp with N=16, OSR_LOG2=2 (R=4).
module tb_sdm_interp;

   logic               clk;
   logic               areset;
   logic [15:0]        s_data;
   logic               s_valid;
   logic               s_ready;
   logic signed [15:0] dout;
   logic               dout_valid;
   logic               underrun;
   logic [15:0]        underrun_cnt;

   int total;
   int bad;
   bit took;

   sdm_interp #(.N(16), .OSR_LOG2(2), .CNTW(16)) dut (
      .clk          (clk),
      .areset       (areset),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock; 'took' records whether a handshake happened at that edge.
   task automatic tick();
      @(negedge clk);
      took = s_valid && s_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      areset  = 1'b1;
      s_valid = 1'b0;
      tick();
      areset = 1'b0;
      #1;
   endtask

   task automatic chk_out(input string tag, input int d, input int v, input int u);
      chk({tag, "_dout"}, int'(dout), d);
      chk({tag, "_valid"}, int'(dout_valid), v);
      chk({tag, "_udr"}, int'(underrun), u);
      $display("step %s dout=%0d valid=%0d udr=%0d cnt=%0d rdy=%0d",
               tag, dout, dout_valid, underrun, underrun_cnt, s_ready);
   endtask

   initial begin
      int data;
      int exp_d;
      bit exp_took;
      total   = 0;
      bad     = 0;
      took    = 1'b0;
      areset  = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'd123;

      // Reset held with a valid sample offered: nothing accepted, outputs cleared.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready", int'(s_ready), 0);
         chk_out("rst", 0, 0, 0);
      end
      areset  = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("rel_ready", int'(s_ready), 1);
      chk("rel_cnt", int'(underrun_cnt), 0);
      tick();
      chk_out("rel", 0, 0, 0);

      // Ramp 0 -> 400 then starve.
      s_valid = 1'b1;
      s_data  = 16'd0;
      tick();
      s_data = 16'd400;
      chk_out("ramp_hold", 0, 1, 0);
      tick();
      s_valid = 1'b0;
      chk_out("ramp_p0", 0, 1, 0);
      tick(); chk_out("ramp_p1", 100, 1, 0);
      tick(); chk_out("ramp_p2", 200, 1, 0);
      tick(); chk_out("ramp_p3", 300, 1, 0);
      tick(); chk_out("ramp_end", 400, 1, 1);
      chk("ramp_cnt1", int'(underrun_cnt), 1);
      tick(); chk_out("ramp_held", 400, 1, 0);
      chk("ramp_cnt1b", int'(underrun_cnt), 1);
      tick(); chk_out("ramp_held2", 400, 1, 0);

      // Full-scale step.
      do_reset();
      chk("fs_cnt0", int'(underrun_cnt), 0);
      s_valid = 1'b1;
      s_data  = 16'h8000;
      tick();
      s_data = 16'h7fff;
      chk_out("fs_hold", -32768, 1, 0);
      tick();
      s_valid = 1'b0;
      chk_out("fs_p0", -32768, 1, 0);
      tick(); chk_out("fs_p1", -16385, 1, 0);
      tick(); chk_out("fs_p2", -1, 1, 0);
      tick(); chk_out("fs_p3", 16383, 1, 0);
      tick(); chk_out("fs_end", 32767, 1, 1);
      chk("fs_cnt", int'(underrun_cnt), 1);

      // Backpressure: source always valid, data advances by 1000 per accept.
      do_reset();
      data    = 1000;
      s_valid = 1'b1;
      s_data  = 16'(data);
      for (int c = 0; c < 18; c++) begin
         tick();
         exp_took = (c <= 1) || ((c - 2) % 4 == 0);
         chk("bp_accept", int'(took), int'(exp_took));
         if (took) begin
            data   = data + 1000;
            s_data = 16'(data);
         end
         exp_d = (c == 0) ? 1000 : 1000 + 250 * (c - 1);
         chk_out("bp", exp_d, 1, 0);
      end
      s_valid = 1'b0;
      chk("bp_cnt", int'(underrun_cnt), 0);

      // Bypass: 800 offered only in the ph=3 cycle of segment 0 -> 400.
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'd0;
      tick();
      s_data = 16'd400;
      tick();
      s_valid = 1'b0;
      chk_out("byp_p0", 0, 1, 0);
      tick(); chk_out("byp_p1", 100, 1, 0);
      tick(); chk_out("byp_p2", 200, 1, 0);
      tick(); chk_out("byp_p3", 300, 1, 0);
      s_valid = 1'b1;
      s_data  = 16'd800;
      tick();
      s_valid = 1'b0;
      chk("byp_took", int'(took), 1);
      chk("byp_ready", int'(s_ready), 1);
      chk_out("byp_q0", 400, 1, 0);
      tick(); chk_out("byp_q1", 500, 1, 0);
      tick(); chk_out("byp_q2", 600, 1, 0);
      tick(); chk_out("byp_q3", 700, 1, 0);
      tick(); chk_out("byp_end", 800, 1, 1);
      chk("byp_cnt", int'(underrun_cnt), 1);

      // Reset in the middle of RUN with a sample sitting in the buffer.
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'd0;
      tick();
      s_data = 16'd400;
      tick();
      s_data = 16'd999;
      tick();
      s_valid = 1'b0;
      chk("mr_buf_full", int'(s_ready), 0);
      chk_out("mr_p1", 100, 1, 0);
      tick();
      chk_out("mr_p2", 200, 1, 0);
      areset = 1'b1;
      #1;
      chk_out("mr_rst", 0, 0, 0);
      chk("mr_rst_ready", int'(s_ready), 0);
      chk("mr_rst_cnt", int'(underrun_cnt), 0);
      tick();
      areset = 1'b0;
      #1;
      chk("mr_rel_ready", int'(s_ready), 1);
      s_valid = 1'b1;
      s_data  = 16'd555;
      tick();
      s_valid = 1'b0;
      chk_out("mr_first", 555, 1, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_out("mr_hold", 555, 1, 0);
         chk("mr_hold_ready", int'(s_ready), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
